imm_encoder: RTL and testbench

Constant-materialisation encoder: the inverse of the datapath immediate extender. It accepts a 32-bit constant and a destination register, then chooses the extension mode (sign, zero, or upper-half) whose extension reproduces the constant. It emits the shortest MIPS instruction sequence that loads the constant: one word, or a lui/ori pair. It sits between the boot/test loader and instruction memory, and generates `li` expansions over a valid/ready stream.

---
 rtl/imm_encoder_if.sv | 37 +++
 rtl/imm_encoder.sv | 159 +++++++++++++++
 tb/tb_imm_encoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder_if
// Description : Valid/ready stream bundle for the constant-materialisation
//               encoder. Input side carries a 32-bit constant plus target
//               register; output side carries encoded MIPS words.
// Ports       : in_valid/in_ready/value/rt      - constant request stream
//               out_valid/out_ready/instr/mode  - instruction word stream
//               out_last                        - last word of a constant
//               word_cnt                        - accepted output words
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic [4:0]  rt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [1:0]  mode;
  logic        out_last;
  logic [15:0] word_cnt;

  // Loader / consumer side
  modport master (
    output in_valid, value, rt, out_ready,
    input  in_ready, out_valid, instr, mode, out_last, word_cnt
  );

  // Encoder side
  modport slave (
    input  in_valid, value, rt, out_ready,
    output in_ready, out_valid, instr, mode, out_last, word_cnt
  );
endinterface
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Turns a 32-bit constant into the shortest MIPS load sequence
//               (addiu / ori / lui, or a lui+ori pair) and streams the words
//               out with the extension mode the consumer must apply.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - imm_encoder_if.slave (request and word streams)
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder (
  input  wire logic     clk,
  input  wire logic     rst_n,
  imm_encoder_if.slave  bus
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_emit1 = 2'd1;
  localparam logic [1:0] c_emit2 = 2'd2;

  localparam logic [5:0] c_op_addiu = 6'b001001;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_lui   = 6'b001111;

  localparam logic [1:0] c_mode_sign  = 2'b00;
  localparam logic [1:0] c_mode_zero  = 2'b01;
  localparam logic [1:0] c_mode_upper = 2'b10;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_instr;
  logic [1:0]  r_mode;
  logic        r_last;
  logic [15:0] r_lo;
  logic [4:0]  r_rt;
  logic [15:0] r_cnt;

  logic        w_accept;
  logic        w_fire;
  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_word;
  logic [1:0]  w_mode;
  logic        w_last;
  logic        w_sext_ok;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_accept) w_state_nxt = c_emit1;
      c_emit1: if (w_fire)   w_state_nxt = r_last ? c_idle : c_emit2;
      c_emit2: if (w_fire)   w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // State-decoded outputs. in_ready is gated by rst_n so the loader never
  // sees a ready while the encoder is held in reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      c_idle:  w_in_ready  = rst_n;
      c_emit1: w_out_valid = 1'b1;
      c_emit2: w_out_valid = 1'b1;
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_fire   = w_out_valid & bus.out_ready;

  // --------------------------------------------------------------------------
  // Classification, first match wins. A constant is sign-extendable from 16
  // bits when bits 31..15 are all the same value.
  // --------------------------------------------------------------------------
  assign w_sext_ok = (&bus.value[31:15]) | ~(|bus.value[31:15]);

  always_comb begin
    w_word = {c_op_lui, 5'd0, bus.rt, bus.value[31:16]};
    w_mode = c_mode_upper;
    w_last = 1'b0;
    if (w_sext_ok) begin
      w_word = {c_op_addiu, 5'd0, bus.rt, bus.value[15:0]};
      w_mode = c_mode_sign;
      w_last = 1'b1;
    end else if (bus.value[31:16] == 16'd0) begin
      w_word = {c_op_ori, 5'd0, bus.rt, bus.value[15:0]};
      w_mode = c_mode_zero;
      w_last = 1'b1;
    end else if (bus.value[15:0] == 16'd0) begin
      w_word = {c_op_lui, 5'd0, bus.rt, bus.value[31:16]};
      w_mode = c_mode_upper;
      w_last = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output word registers. The low half and rt are kept so the ori word can
  // be built in the same edge that retires the lui word, avoiding a bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 32'd0;
      r_mode  <= c_mode_sign;
      r_last  <= 1'b0;
      r_lo    <= 16'd0;
      r_rt    <= 5'd0;
    end else if (w_accept) begin
      r_instr <= w_word;
      r_mode  <= w_mode;
      r_last  <= w_last;
      r_lo    <= bus.value[15:0];
      r_rt    <= bus.rt;
    end else if ((r_state == c_emit1) && w_fire && !r_last) begin
      r_instr <= {c_op_ori, r_rt, r_rt, r_lo};
      r_mode  <= c_mode_zero;
      r_last  <= 1'b1;
    end
  end

  // Accepted-word counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (w_fire) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.instr     = r_instr;
  assign bus.mode      = r_mode;
  assign bus.out_last  = r_last;
  assign bus.word_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Self-checking bench for imm_encoder. Table of constants with
//               hand-computed words, plus backpressure and mid-sequence
//               reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

  logic clk;
  logic rst_n;
  imm_encoder_if bus ();

  imm_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  rt;
    logic [31:0] w1;
    logic [1:0]  m1;
    logic        two;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs [11];
  int   n_cmp;
  int   n_err;
  int   exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with the encoder idle; out_ready held 1.
  task automatic run_vec(input vec_t v);
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.value     = v.value;
    bus.rt        = v.rt;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("w1_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("w1_instr", bus.instr, v.w1);
    chk("w1_mode",  {30'd0, bus.mode}, {30'd0, v.m1});
    chk("w1_last",  {31'd0, bus.out_last}, {31'd0, ~v.two});
    chk("w1_cnt",   {16'd0, bus.word_cnt}, exp_cnt);
    exp_cnt++;
    if (v.two) begin
      @(negedge clk);
      chk("w2_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("w2_instr", bus.instr, v.w2);
      chk("w2_mode",  {30'd0, bus.mode}, 32'd1);
      chk("w2_last",  {31'd0, bus.out_last}, 32'd1);
      exp_cnt++;
    end
    @(negedge clk);
    chk("done_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("done_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("done_cnt",   {16'd0, bus.word_cnt}, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_cnt = 0;

    vecs[0]  = '{32'hFFFF8000, 5'd8,  32'h24088000, 2'b00, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000ABCD, 5'd9,  32'h3409ABCD, 2'b01, 1'b0, 32'h0};
    vecs[2]  = '{32'h00008000, 5'd9,  32'h34098000, 2'b01, 1'b0, 32'h0};
    vecs[3]  = '{32'h00000000, 5'd9,  32'h24090000, 2'b00, 1'b0, 32'h0};
    vecs[4]  = '{32'h12340000, 5'd10, 32'h3C0A1234, 2'b10, 1'b0, 32'h0};
    vecs[5]  = '{32'hFFFF0000, 5'd10, 32'h3C0AFFFF, 2'b10, 1'b0, 32'h0};
    vecs[6]  = '{32'h12345678, 5'd11, 32'h3C0B1234, 2'b10, 1'b1, 32'h356B5678};
    vecs[7]  = '{32'hFFFFFFFF, 5'd0,  32'h2400FFFF, 2'b00, 1'b0, 32'h0};
    vecs[8]  = '{32'h80000000, 5'd31, 32'h3C1F8000, 2'b10, 1'b0, 32'h0};
    vecs[9]  = '{32'h80000001, 5'd31, 32'h3C1F8000, 2'b10, 1'b1, 32'h37FF0001};
    vecs[10] = '{32'h00007FFF, 5'd1,  32'h24017FFF, 2'b00, 1'b0, 32'h0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.value     = 32'd0;
    bus.rt        = 5'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_instr",     bus.instr, 32'd0);
    chk("rst_mode",      {30'd0, bus.mode}, 32'd0);
    chk("rst_last",      {31'd0, bus.out_last}, 32'd0);
    chk("rst_cnt",       {16'd0, bus.word_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Backpressure on both words of a pair, with stray in_valid pulses.
    bus.in_valid  = 1'b1;
    bus.value     = 32'h12345678;
    bus.rt        = 5'd11;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.value = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = ~bus.in_valid;
      chk("bp1_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp1_instr", bus.instr, 32'h3C0B1234);
      chk("bp1_last",  {31'd0, bus.out_last}, 32'd0);
      chk("bp1_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp1_cnt",   {16'd0, bus.word_cnt}, exp_cnt);
      @(negedge clk);
    end
    chk("bp1_instr_end", bus.instr, 32'h3C0B1234);
    bus.out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = ~bus.in_valid;
      chk("bp2_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp2_instr", bus.instr, 32'h356B5678);
      chk("bp2_mode",  {30'd0, bus.mode}, 32'd1);
      chk("bp2_last",  {31'd0, bus.out_last}, 32'd1);
      chk("bp2_cnt",   {16'd0, bus.word_cnt}, exp_cnt);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    exp_cnt++;
    chk("bp_done_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_done_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_done_cnt",   {16'd0, bus.word_cnt}, exp_cnt);

    // Reset while the second word is pending.
    bus.in_valid  = 1'b1;
    bus.value     = 32'h12345678;
    bus.rt        = 5'd11;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("rm_w2_instr", bus.instr, 32'h356B5678);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rm_cnt",       {16'd0, bus.word_cnt}, 32'd0);
    chk("rm_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    chk("rm_instr",     bus.instr, 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rm_after_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rm_after_cnt",   {16'd0, bus.word_cnt}, 32'd0);
    run_vec(vecs[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
